// File: rtl/shared_reg_if.sv
// Requester-side bus of the shared register arbiter: requests/data in, grant/ack/readback out.
// Parity outputs exist only when SHARED_REG_PARITY_EN is defined.
interface shared_reg_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     ack;
  logic [2:0]               owner;
  logic                     busy;
  logic [WIDTH-1:0]         q;
`ifdef SHARED_REG_PARITY_EN
  logic                     par;
  logic                     perr;
`endif

  modport master (
    output req, wr_data,
`ifdef SHARED_REG_PARITY_EN
    input  par, perr,
`endif
    input  gnt, ack, owner, busy, q
  );

  modport slave (
    input  req, wr_data,
`ifdef SHARED_REG_PARITY_EN
    output par, perr,
`endif
    output gnt, ack, owner, busy, q
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter + IDLE->GRANT->ACK write sequencer for one shared WIDTH-bit register.
// Optional parity on the register (par/perr) is enabled by defining SHARED_REG_PARITY_EN.
module shared_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  shared_reg_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2} state_t;

  state_t                       state, state_nxt;
  logic [2:0]                   ptr, owner_r, win_idx;
  logic                         win_vld;
  logic                         busy_c, ack_c;
  logic [NUM_REQ-1:0][WIDTH-1:0] data_v;
  logic [WIDTH-1:0]             q_r, ld_data;
  logic [3:0]                   cand;

  assign data_v = bus.wr_data;

  // Cyclic search starting one past the last winner; first set bit wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_vld && cand == 4'(i) && bus.req[i]) begin
          win_vld = 1'b1;
          win_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    ack_c     = 1'b0;
    unique case (state)
      IDLE:  if (win_vld) state_nxt = GRANT;
      GRANT: begin
        busy_c    = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        busy_c    = 1'b1;
        ack_c     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (owner_r == 3'(i)) ld_data = data_v[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'(NUM_REQ - 1);
      owner_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        owner_r <= win_idx;
        ptr     <= win_idx;
      end
    end
  end

  // Data is taken at the edge closing GRANT, regardless of req at that point.
  always_ff @(posedge clk) begin
    if (rst)                 q_r <= '0;
    else if (state == GRANT) q_r <= ld_data;
  end

`ifdef SHARED_REG_PARITY_EN
  logic par_r;
  always_ff @(posedge clk) begin
    if (rst)                 par_r <= 1'b0;
    else if (state == GRANT) par_r <= ^ld_data;
  end
  assign bus.par  = par_r;
  assign bus.perr = par_r ^ (^q_r);
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_gnt
    assign bus.gnt[i] = busy_c && (owner_r == 3'(i));
  end

  assign bus.ack   = ack_c;
  assign bus.busy  = busy_c;
  assign bus.owner = owner_r;
  assign bus.q     = q_r;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed, table-driven bench for shared_reg_arbiter (NUM_REQ=4, WIDTH=4).
module tb_shared_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shared_reg_if #(.NUM_REQ(4), .WIDTH(4)) bus ();
  shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] wd;
    logic [3:0]  gnt;
    logic        ack;
    logic        busy;
    logic [2:0]  owner;
    logic [3:0]  q;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] wd,
                     input logic [3:0] g, input logic a, input logic b,
                     input logic [2:0] o, input logic [3:0] qq);
    vec_t v;
    v.rst = r; v.req = rq; v.wd = wd; v.gnt = g; v.ack = a; v.busy = b; v.owner = o; v.q = qq;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] wd);
    @(negedge clk);
    rst = r; bus.req = rq; bus.wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int row, input vec_t v);
    chk("gnt",   row, 32'(bus.gnt),   32'(v.gnt));
    chk("ack",   row, 32'(bus.ack),   32'(v.ack));
    chk("busy",  row, 32'(bus.busy),  32'(v.busy));
    chk("owner", row, 32'(bus.owner), 32'(v.owner));
    chk("q",     row, 32'(bus.q),     32'(v.q));
  endtask

  initial begin
    bus.req = '1; bus.wr_data = '0;
    // reset with all requests high
    add(1, 4'hF, 16'h4321, 4'b0000, 0, 0, 0, 4'h0);
    add(1, 4'hF, 16'h4321, 4'b0000, 0, 0, 0, 4'h0);
    add(0, 4'hF, 16'h4321, 4'b0001, 0, 1, 0, 4'h0);
    add(0, 4'hF, 16'h4321, 4'b0001, 1, 1, 0, 4'h1);
    add(0, 4'h0, 16'h4321, 4'b0000, 0, 0, 0, 4'h1);
    // single requester 1, data A
    add(0, 4'b0010, 16'h43A1, 4'b0010, 0, 1, 1, 4'h1);
    add(0, 4'b0000, 16'h43A1, 4'b0010, 1, 1, 1, 4'hA);
    add(0, 4'b0000, 16'h43A1, 4'b0000, 0, 0, 1, 4'hA);
    // full contention after fresh reset: order 0,1,2,3,0
    add(1, 4'hF, 16'h4321, 4'b0000, 0, 0, 0, 4'h0);
    add(0, 4'hF, 16'h4321, 4'b0001, 0, 1, 0, 4'h0);
    add(0, 4'hF, 16'h4321, 4'b0001, 1, 1, 0, 4'h1);
    add(0, 4'hF, 16'h4321, 4'b0000, 0, 0, 0, 4'h1);
    add(0, 4'hF, 16'h4321, 4'b0010, 0, 1, 1, 4'h1);
    add(0, 4'hF, 16'h4321, 4'b0010, 1, 1, 1, 4'h2);
    add(0, 4'hF, 16'h4321, 4'b0000, 0, 0, 1, 4'h2);
    add(0, 4'hF, 16'h4321, 4'b0100, 0, 1, 2, 4'h2);
    add(0, 4'hF, 16'h4321, 4'b0100, 1, 1, 2, 4'h3);
    add(0, 4'hF, 16'h4321, 4'b0000, 0, 0, 2, 4'h3);
    add(0, 4'hF, 16'h4321, 4'b1000, 0, 1, 3, 4'h3);
    add(0, 4'hF, 16'h4321, 4'b1000, 1, 1, 3, 4'h4);
    add(0, 4'hF, 16'h4321, 4'b0000, 0, 0, 3, 4'h4);
    add(0, 4'hF, 16'h4321, 4'b0001, 0, 1, 0, 4'h4);
    add(0, 4'hF, 16'h4321, 4'b0001, 1, 1, 0, 4'h1);
    add(0, 4'hF, 16'h4321, 4'b0000, 0, 0, 0, 4'h1);
    // move pointer to 2, then req[3]+req[0] alternate across the wrap
    add(0, 4'b0100, 16'h4321, 4'b0100, 0, 1, 2, 4'h1);
    add(0, 4'b1001, 16'h4321, 4'b0100, 1, 1, 2, 4'h3);
    add(0, 4'b1001, 16'h4321, 4'b0000, 0, 0, 2, 4'h3);
    add(0, 4'b1001, 16'h4321, 4'b1000, 0, 1, 3, 4'h3);
    add(0, 4'b1001, 16'h4321, 4'b1000, 1, 1, 3, 4'h4);
    add(0, 4'b1001, 16'h4321, 4'b0000, 0, 0, 3, 4'h4);
    add(0, 4'b1001, 16'h4321, 4'b0001, 0, 1, 0, 4'h4);
    add(0, 4'b1001, 16'h4321, 4'b0001, 1, 1, 0, 4'h1);
    add(0, 4'b1001, 16'h4321, 4'b0000, 0, 0, 0, 4'h1);
    add(0, 4'b1001, 16'h4321, 4'b1000, 0, 1, 3, 4'h1);
    add(0, 4'b0000, 16'h4321, 4'b1000, 1, 1, 3, 4'h4);
    add(0, 4'b0000, 16'h4321, 4'b0000, 0, 0, 3, 4'h4);
    // idle with no requests: nothing moves
    add(0, 4'b0000, 16'hFFFF, 4'b0000, 0, 0, 3, 4'h4);
    // write 5, then reset during the GRANT of a write of 7
    add(0, 4'b0001, 16'h0005, 4'b0001, 0, 1, 0, 4'h4);
    add(0, 4'b0000, 16'h0005, 4'b0001, 1, 1, 0, 4'h5);
    add(0, 4'b0000, 16'h0005, 4'b0000, 0, 0, 0, 4'h5);
    add(0, 4'b0010, 16'h0070, 4'b0010, 0, 1, 1, 4'h5);
    add(1, 4'b0010, 16'h0070, 4'b0000, 0, 0, 0, 4'h0);
    add(0, 4'b0000, 16'h0070, 4'b0000, 0, 0, 0, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].wd);
      chk_all(i, tbl[i]);
    end

    // data sampled at the GRANT closing edge, load kept though req drops
    step(0, 4'b0100, 16'h0100);
    chk("late_gnt", 100, 32'(bus.gnt), 32'h4);
    step(0, 4'b0000, 16'h0900);
    chk("late_q",   101, 32'(bus.q),   32'h9);
    chk("late_ack", 101, 32'(bus.ack), 32'h1);
    step(0, 4'b0000, 16'h0900);
    chk("late_idle", 102, 32'(bus.busy), 32'h0);

`ifdef SHARED_REG_PARITY_EN
    step(1, 4'b0000, 16'h0000);
    chk("par_rst", 200, 32'(bus.par), 32'h0);
    step(0, 4'b0001, 16'h000B);
    step(0, 4'b0000, 16'h000B);
    chk("par_b",  201, 32'(bus.par),  32'h1);
    chk("perr_b", 201, 32'(bus.perr), 32'h0);
    step(0, 4'b0000, 16'h000B);
    step(0, 4'b0001, 16'h0003);
    step(0, 4'b0000, 16'h0003);
    chk("q_3",    202, 32'(bus.q),    32'h3);
    chk("par_3",  202, 32'(bus.par),  32'h0);
    chk("perr_3", 202, 32'(bus.perr), 32'h0);
    force dut.q_r = 4'h2;
    #1;
    chk("perr_upset", 203, 32'(bus.perr), 32'h1);
    release dut.q_r;
    step(1, 4'b0000, 16'h0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared 4-bit storage register, the same D-flip-flop register used elsewhere in the lab datapath.
- Up to NUM_REQ requesters compete for write access. One winner per transaction is granted, its data is loaded into the register, and the load is acknowledged.
- Sits between requester blocks (counters, input latches) and the shared register. The register output is the single readback value for all requesters.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 4, data width of the shared register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  per-requester write request; level-sensitive.
- wr_data  input  NUM_REQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  one-hot grant; all zero when idle.
- ack  output  1  one-cycle pulse: register has just been loaded by the granted requester.
- owner  output  3  index of the current or most recent winner.
- busy  output  1  high in GRANT and ACK states.
- q  output  WIDTH  shared register contents.

Behaviour:
- Reset: one clock with rst=1 forces the following.
  - State is IDLE.
  - q=0, gnt=0, ack=0, busy=0, owner=0.
  - Round-robin pointer = NUM_REQ-1, so req[0] has highest priority first.
  - rst overrides every other input, including mid-transaction. A GRANT in flight when rst is sampled high does not load q.
- State machine: IDLE -> GRANT -> ACK -> IDLE.
- IDLE:
  - gnt=0, ack=0, busy=0.
  - If any req bit is 1, select the winner: the first set bit searching cyclically from pointer+1.
  - Register the winner into owner and the pointer, then go to GRANT.
  - If no req bit is set, stay in IDLE.
- GRANT (exactly 1 cycle):
  - gnt[owner]=1, busy=1.
  - At the closing edge, q <= wr_data slice for owner. Data is sampled at that edge, not earlier.
  - The load is committed even if req[owner] drops during GRANT.
  - Next state is ACK.
- ACK (exactly 1 cycle):
  - gnt[owner] stays 1, ack=1, busy=1, and q shows the new value.
  - Next state is IDLE unconditionally.
- Timing and throughput:
  - req sampled at edge 0 -> gnt high in cycle 1 -> q updated at edge 2 -> ack high in cycle 2 -> IDLE in cycle 3.
  - Minimum 3 cycles per write. The earliest next grant is cycle 4.
- Fairness:
  - The pointer advances only on a win.
  - A requester holding req continuously is served again only after every other active requester has been served once.
- Requester obligations:
  - Requester should drop req in the ACK cycle. If req is still high in IDLE, it is treated as a new request.
  - wr_data must be stable during GRANT.
- Boundary conditions:
  - A req bit with index >= NUM_REQ does not exist.
  - Pointer wrap from NUM_REQ-1 to 0 is cyclic.
  - All-zero req in IDLE: no state change and q holds.
- owner width is fixed at 3 bits; upper bits are 0 when NUM_REQ <= 4.
- gnt is never multi-hot. ack is never high outside ACK.

Optional Feature:
- Macro: SHARED_REG_PARITY_EN.
- Defined:
  - Adds output port par (1 bit), registered together with q. par <= ^(loaded data) at the GRANT closing edge, and par=0 on reset.
  - Adds output perr (1 bit), combinationally high when par != ^q. This flags an upset in the shared register.
- Undefined:
  - Ports par and perr are absent. No parity logic is present.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> q=0, gnt=0, ack=0, busy=0, owner=0. After rst falls, the first grant goes to req[0].
- Single requester: req=4'b0010, wr_data slice1=4'hA -> gnt=4'b0010 in cycle 1. In cycle 2, q=4'hA, ack=1, owner=1. Cycle 3 is IDLE with gnt=0.
- Full contention: req=4'b1111 held, slices 0..3 = 1,2,3,4 -> grant order 0,1,2,3,0. q sequence is 1,2,3,4,1 with ack every 3 cycles.
- Fairness under wrap: req[3] and req[0] held with pointer=2 -> winners alternate 3,0,3,0. req[1] and req[2] are never granted.
- Reset mid-op: assert rst during the GRANT cycle of a write of 4'h7 over q=4'h5 -> next cycle q=0, gnt=0, state IDLE. q never equals 7.
- With SHARED_REG_PARITY_EN: write 4'hB -> par=1, perr=0. Write 4'h3 -> par=0. Force q bit0 flipped in simulation -> perr=1.
